// File: rtl/vproc_axi_pkg.sv
// Shared AXI definitions for the VProc manager BFM and its responder:
// channel FSM encodings and the response code every transaction returns.
package vproc_axi_pkg;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_dp_ram.sv
// Simple dual-port word memory: one synchronous write port, one synchronous
// registered read port. A same-address read and write on one edge returns
// the old contents.
module axi_dp_ram #(
  parameter int DATAWIDTH = 32,
  parameter int MEMBITS   = 10
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [MEMBITS-1:0]   wr_addr_i,
  input  logic [DATAWIDTH-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [MEMBITS-1:0]   rd_addr_i,
  output logic [DATAWIDTH-1:0] rd_data_o
);

  logic [DATAWIDTH-1:0] mem_q [1 << MEMBITS];
  logic [DATAWIDTH-1:0] rd_data_q;

  // Write and registered read of the storage array.
  // NOTE: the array has no reset so it maps onto RAM macros; the non-blocking
  // read below sees the pre-edge contents, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4_responder.sv
// Single-beat AXI4 subordinate serving the VProc manager BFM: word memory,
// a software-visible interrupt register, independent write and read FSMs
// with registered handshakes and a configurable read latency.
module axi4_responder
  import vproc_axi_pkg::*;
#(
  parameter int                   ADDRWIDTH = 32,
  parameter int                   DATAWIDTH = 32,
  parameter int                   MEMBITS   = 10,
  parameter int                   RDLATENCY = 1,
  parameter int                   IRQWIDTH  = 32,
  parameter logic [ADDRWIDTH-1:0] IRQADDR   = 32'hFFFF_FFF0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [2:0]           awprot,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic                 wlast,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [ADDRWIDTH-1:0] araddr,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [2:0]           arprot,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [IRQWIDTH-1:0]  irq
);

  localparam int B    = $clog2(DATAWIDTH / 8);
  localparam int CNTW = (RDLATENCY > 2) ? $clog2(RDLATENCY) : 1;

  function automatic logic [MEMBITS-1:0] word_idx(input logic [ADDRWIDTH-1:0] a);
    return a[MEMBITS+B-1:B];
  endfunction

  // Protection and last-beat signals carry no meaning for a single-beat model.
  logic unused_inputs;
  assign unused_inputs = ^{awprot, arprot, wlast};

  // ---------------- write channel ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDRWIDTH-1:0]  aw_q, aw_d;
  logic [DATAWIDTH-1:0]  w_q, w_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [IRQWIDTH-1:0]   irq_q, irq_d;
  logic                  aw_hs, w_hs;
  logic                  ram_we;
  logic [MEMBITS-1:0]    ram_wa;

  // Capture AW/W independently, commit once both are held, then respond.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    aw_hs      = awvalid & awready_q;
    w_hs       = wvalid & wready_q;
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    aw_d       = aw_q;
    w_d        = w_q;
    irq_d      = irq_q;
    ram_we     = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_d      = awaddr;
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          w_d      = wdata;
        end
        if (aw_full_d && w_full_d) begin
          if (aw_d == IRQADDR) irq_d = w_d[IRQWIDTH-1:0];
          else                 ram_we = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_q && bready) begin
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    ram_wa    = word_idx(aw_d);
    awready_d = (wr_state_d == WR_IDLE) && !aw_full_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_full_d;
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  // Write-channel control state and interrupt register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      irq_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      irq_q      <= irq_d;
    end
  end

  // Write address/data holding registers; qualified by the full flags.
  always_ff @(posedge clk) begin
    aw_q <= aw_d;
    w_q  <= w_d;
  end

  // ---------------- read channel ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]  ar_q, ar_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic                  rd_irq_q, rd_irq_d;
  logic [IRQWIDTH-1:0]   irq_snap_q, irq_snap_d;
  logic                  ar_hs, rd_load;
  logic [DATAWIDTH-1:0]  ram_rdata;

  // Accept an address, wait out the latency, load data on entry to RD_RESP.
  always_comb begin
    ar_hs      = arvalid & arready_q;
    rd_state_d = rd_state_q;
    cnt_d      = cnt_q;
    ar_d       = ar_q;
    rd_load    = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          ar_d = araddr;
          if (RDLATENCY == 1) begin
            rd_state_d = RD_RESP;
            rd_load    = 1'b1;
          end else begin
            rd_state_d = RD_WAIT;
            cnt_d      = CNTW'(RDLATENCY - 2);
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rd_state_d = RD_RESP;
          rd_load    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RD_RESP: if (rvalid_q && rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
    rd_irq_d   = rd_load ? (ar_d == IRQADDR) : rd_irq_q;
    irq_snap_d = rd_load ? irq_q : irq_snap_q;
    arready_d  = (rd_state_d == RD_IDLE);
    rvalid_d   = (rd_state_d == RD_RESP);
  end

  // Read-channel control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      cnt_q      <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      cnt_q      <= cnt_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Read address and response source; only meaningful while rvalid is high.
  always_ff @(posedge clk) begin
    ar_q       <= ar_d;
    rd_irq_q   <= rd_irq_d;
    irq_snap_q <= irq_snap_d;
  end

  axi_dp_ram #(
    .DATAWIDTH (DATAWIDTH),
    .MEMBITS   (MEMBITS)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_wa),
    .wr_data_i (w_d),
    .rd_en_i   (rd_load),
    .rd_addr_i (word_idx(ar_d)),
    .rd_data_o (ram_rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign irq     = irq_q;
  assign rdata   = rvalid_q ? (rd_irq_q ? DATAWIDTH'(irq_snap_q) : ram_rdata) : 'x;

endmodule

// File: tb/tb_axi4_responder.sv
// Bench for axi4_responder: two instances (read latency 1 and 4) driven by
// directed scenarios then random traffic, checked every cycle against a
// transaction-level model of the memory, irq register and channel timing.
module tb_axi4_responder;

  localparam logic [31:0] IRQA = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr  [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] irq     [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi4_responder #(.RDLATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]), .awprot(3'b000),
    .wdata(wdata[0]), .wvalid(wvalid[0]), .wready(wready[0]), .wlast(1'b1),
    .bvalid(bvalid[0]), .bready(bready[0]),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]), .arprot(3'b000),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .rready(rready[0]), .irq(irq[0])
  );

  axi4_responder #(.RDLATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]), .awprot(3'b000),
    .wdata(wdata[1]), .wvalid(wvalid[1]), .wready(wready[1]), .wlast(1'b1),
    .bvalid(bvalid[1]), .bready(bready[1]),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]), .arprot(3'b000),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .rready(rready[1]), .irq(irq[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          lat [2] = '{1, 4};
  bit          model_live = 0;
  bit          aw_got [2], w_got [2], b_pend [2], rd_busy [2], r_pend [2];
  int          cnt [2];
  logic [31:0] aw_a [2], w_v [2], ar_a [2], irq_m [2];
  logic [31:0] mem_m [int];
  bit          exp_awready [2], exp_wready [2], exp_bvalid [2], exp_arready [2], exp_rvalid [2];
  logic [31:0] exp_rdata [2];
  bit          exp_rknown [2];

  function automatic int key(input int d, input logic [31:0] a);
    return d * 4096 + int'((a >> 2) & 32'h3FF);
  endfunction

  always @(posedge clk) begin
    bit aw_h, w_h, b_h, ar_h, r_h;
    if (rst) model_live = 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        aw_got[d] = 0; w_got[d] = 0; b_pend[d] = 0;
        rd_busy[d] = 0; r_pend[d] = 0; irq_m[d] = '0;
        exp_awready[d] = 0; exp_wready[d] = 0; exp_bvalid[d] = 0;
        exp_arready[d] = 0; exp_rvalid[d] = 0;
      end else begin
        aw_h = awvalid[d] && exp_awready[d];
        w_h  = wvalid[d] && exp_wready[d];
        b_h  = bready[d] && exp_bvalid[d];
        ar_h = arvalid[d] && exp_arready[d];
        r_h  = rready[d] && exp_rvalid[d];
        // read side first: data is taken before this edge's write lands
        if (r_h) begin r_pend[d] = 0; rd_busy[d] = 0; end
        if (ar_h) begin rd_busy[d] = 1; cnt[d] = lat[d]; ar_a[d] = araddr[d]; end
        if (rd_busy[d] && !r_pend[d]) begin
          cnt[d]--;
          if (cnt[d] == 0) begin
            r_pend[d] = 1;
            if (ar_a[d] == IRQA) begin
              exp_rdata[d] = irq_m[d]; exp_rknown[d] = 1;
            end else if (mem_m.exists(key(d, ar_a[d]))) begin
              exp_rdata[d] = mem_m[key(d, ar_a[d])]; exp_rknown[d] = 1;
            end else exp_rknown[d] = 0;
          end
        end
        if (b_h) begin aw_got[d] = 0; w_got[d] = 0; b_pend[d] = 0; end
        if (aw_h) begin aw_got[d] = 1; aw_a[d] = awaddr[d]; end
        if (w_h) begin w_got[d] = 1; w_v[d] = wdata[d]; end
        if (aw_got[d] && w_got[d] && !b_pend[d]) begin
          if (aw_a[d] == IRQA) irq_m[d] = w_v[d];
          else mem_m[key(d, aw_a[d])] = w_v[d];
          b_pend[d] = 1;
        end
        exp_awready[d] = !aw_got[d] && !b_pend[d];
        exp_wready[d]  = !w_got[d] && !b_pend[d];
        exp_bvalid[d]  = b_pend[d];
        exp_arready[d] = !rd_busy[d];
        exp_rvalid[d]  = r_pend[d];
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("awready[%0d]", d), awready[d], exp_awready[d]);
        check($sformatf("wready[%0d]", d), wready[d], exp_wready[d]);
        check($sformatf("bvalid[%0d]", d), bvalid[d], exp_bvalid[d]);
        check($sformatf("arready[%0d]", d), arready[d], exp_arready[d]);
        check($sformatf("rvalid[%0d]", d), rvalid[d], exp_rvalid[d]);
        check($sformatf("irq[%0d]", d), irq[d], irq_m[d]);
        if (exp_rvalid[d] && exp_rknown[d])
          check($sformatf("rdata[%0d]", d), rdata[d], exp_rdata[d]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_txn(input int d, input logic [31:0] a, input logic [31:0] v);
    bit done;
    done = 0;
    awaddr[d] = a; wdata[d] = v;
    awvalid[d] = 1; wvalid[d] = 1; bready[d] = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      bit aw_h, w_h, b_h;
      aw_h = awvalid[d] && awready[d];
      w_h  = wvalid[d] && wready[d];
      b_h  = bvalid[d] && bready[d];
      step();
      if (aw_h) awvalid[d] = 0;
      if (w_h) wvalid[d] = 0;
      if (b_h) done = 1;
    end
    awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0;
    check("write_done", done, 1);
  endtask

  task automatic read_txn(input int d, input logic [31:0] a, output logic [31:0] v);
    bit done;
    done = 0; v = '0;
    araddr[d] = a; arvalid[d] = 1; rready[d] = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      bit ar_h, r_h;
      ar_h = arvalid[d] && arready[d];
      r_h  = rvalid[d] && rready[d];
      if (r_h) v = rdata[d];
      step();
      if (ar_h) arvalid[d] = 0;
      if (r_h) done = 1;
    end
    arvalid[d] = 0; rready[d] = 0;
    check("read_done", done, 1);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 6))
      0:       return IRQA;
      1:       return 32'h10;
      2:       return 32'h1010;
      3:       return 32'hFF0;
      4:       return 32'h40;
      default: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios then random traffic ----------------
  initial begin
    logic [31:0] v;
    int n;
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      awaddr[d] = '0; awvalid[d] = 0; wdata[d] = '0; wvalid[d] = 0; bready[d] = 0;
      araddr[d] = '0; arvalid[d] = 0; rready[d] = 0;
    end

    // reset: everything low, readies rise one cycle after release
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) begin
        check("rst_awready", awready[d], 0);
        check("rst_arready", arready[d], 0);
        check("rst_bvalid", bvalid[d], 0);
        check("rst_irq", irq[d], 0);
      end
    end
    rst = 0;
    step();
    check("post_rst_awready", awready[0], 1);
    check("post_rst_wready", wready[1], 1);
    check("post_rst_arready", arready[0], 1);

    // AW and W together, read back with latency 1
    awaddr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; awvalid[0] = 1; wvalid[0] = 1;
    step();
    awvalid[0] = 0; wvalid[0] = 0;
    check("t2_bvalid", bvalid[0], 1);
    check("t2_awready_drop", awready[0], 0);
    bready[0] = 1; step(); bready[0] = 0;
    check("t2_awready_back", awready[0], 1);
    araddr[0] = 32'h10; arvalid[0] = 1;
    step();
    arvalid[0] = 0;
    check("t2_rvalid", rvalid[0], 1);
    check("t2_rdata", rdata[0], 32'hDEADBEEF);
    rready[0] = 1; step(); rready[0] = 0;
    check("t2_rvalid_clr", rvalid[0], 0);
    check("t2_arready_back", arready[0], 1);

    // AW first, W three cycles later
    awaddr[0] = 32'h20; awvalid[0] = 1; step(); awvalid[0] = 0;
    repeat (2) begin
      check("t3_awready_low", awready[0], 0);
      check("t3_no_bvalid", bvalid[0], 0);
      step();
    end
    wdata[0] = 32'h1234; wvalid[0] = 1; step(); wvalid[0] = 0;
    check("t3_bvalid_aw_first", bvalid[0], 1);
    bready[0] = 1; step(); bready[0] = 0;
    // W first, AW three cycles later
    wdata[0] = 32'h1234; wvalid[0] = 1; step(); wvalid[0] = 0;
    repeat (2) begin
      check("t3_wready_low", wready[0], 0);
      check("t3_no_bvalid_w", bvalid[0], 0);
      step();
    end
    awaddr[0] = 32'h24; awvalid[0] = 1; step(); awvalid[0] = 0;
    check("t3_bvalid_w_first", bvalid[0], 1);
    bready[0] = 1; step(); bready[0] = 0;
    read_txn(0, 32'h20, v); check("t3_rd20", v, 32'h1234);
    read_txn(0, 32'h24, v); check("t3_rd24", v, 32'h1234);

    // B back-pressure while a second write waits
    awaddr[0] = 32'h30; wdata[0] = 32'h3030; awvalid[0] = 1; wvalid[0] = 1;
    step();
    awaddr[0] = 32'h34; wdata[0] = 32'h3434;
    repeat (4) begin
      step();
      check("t4_bvalid_hold", bvalid[0], 1);
      check("t4_awready_low", awready[0], 0);
      check("t4_wready_low", wready[0], 0);
    end
    bready[0] = 1; step(); bready[0] = 0;
    check("t4_bvalid_clr", bvalid[0], 0);
    check("t4_awready_back", awready[0], 1);
    step();
    awvalid[0] = 0; wvalid[0] = 0;
    check("t4_second_bvalid", bvalid[0], 1);
    bready[0] = 1; step(); bready[0] = 0;
    read_txn(0, 32'h30, v); check("t4_rd30", v, 32'h3030);
    read_txn(0, 32'h34, v); check("t4_rd34", v, 32'h3434);

    // interrupt register and its aliased memory word
    write_txn(0, 32'hFF0, 32'hA5A50001);
    awaddr[0] = IRQA; wdata[0] = 32'h5; awvalid[0] = 1; wvalid[0] = 1;
    step();
    awvalid[0] = 0; wvalid[0] = 0;
    check("t5_irq", irq[0], 32'h5);
    check("t5_bvalid", bvalid[0], 1);
    bready[0] = 1; step(); bready[0] = 0;
    read_txn(0, IRQA, v); check("t5_rd_irq", v, 32'h5);
    read_txn(0, 32'hFF0, v); check("t5_alias", v, 32'hA5A50001);

    // latency 4, then reset while waiting
    write_txn(1, 32'h40, 32'hC0FFEE01);
    araddr[1] = 32'h40; arvalid[1] = 1;
    step();
    arvalid[1] = 0;
    n = 1;
    while (!rvalid[1] && n < 20) begin step(); n++; end
    check("t6_latency", n, 4);
    check("t6_rdata", rdata[1], 32'hC0FFEE01);
    rready[1] = 1; step(); rready[1] = 0;
    araddr[1] = 32'h40; arvalid[1] = 1; step(); arvalid[1] = 0;
    step();
    rst = 1; step();
    check("t6_rst_rvalid", rvalid[1], 0);
    rst = 0; step();
    check("t6_arready_after_rst", arready[1], 1);
    repeat (3) begin step(); check("t6_no_rvalid", rvalid[1], 0); end
    read_txn(1, 32'h40, v); check("t6_mem_kept", v, 32'hC0FFEE01);

    // random concurrent traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        awvalid[d] = 1'($urandom_range(0, 1));
        awaddr[d]  = pick_addr();
        wvalid[d]  = 1'($urandom_range(0, 1));
        wdata[d]   = $urandom;
        bready[d]  = 1'($urandom_range(0, 1));
        arvalid[d] = 1'($urandom_range(0, 1));
        araddr[d]  = pick_addr();
        rready[d]  = 1'($urandom_range(0, 1));
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0; bready[d] = 1; rready[d] = 1;
    end
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
